// File: rtl/weight_update_module.sv
// Batch-accumulating weight update stage: sums dw per weight over 2**BATCH_LOG2 samples,
// then sweeps the bank applying w -= acc >>> (BATCH_LOG2+LR_SHIFT). Optional macro WU_GRAD_CLIP_EN.
module weight_update_module #(
    parameter int unsigned       N_W        = 8,
    parameter int unsigned       ADDR_W     = 3,
    parameter int unsigned       BATCH_LOG2 = 2,
    parameter int unsigned       LR_SHIFT   = 4,
    parameter logic signed [15:0] W_INIT    = 16'sd0,
    parameter logic signed [15:0] GRAD_CLIP = 16'sd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dw_valid,
    input  logic [ADDR_W-1:0]     dw_idx,
    input  logic [15:0]           dw,
    output logic                  dw_ready,
    input  logic                  sample_done,
    input  logic                  w_load,
    input  logic [ADDR_W-1:0]     w_load_idx,
    input  logic [15:0]           w_load_data,
    input  logic [ADDR_W-1:0]     rd_idx,
    output logic [15:0]           rd_w,
    output logic                  upd_busy,
    output logic                  upd_done,
    output logic [BATCH_LOG2-1:0] batch_cnt
);

    localparam int unsigned Shift = BATCH_LOG2 + LR_SHIFT;

    typedef enum logic [0:0] {StAccum, StApply} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      k_q, k_d;
    logic [BATCH_LOG2-1:0]  batch_q, batch_d;
    logic                   done_q, done_d;
    logic signed [23:0]     acc_q [N_W];
    logic signed [23:0]     acc_d [N_W];
    logic signed [15:0]     w_q [N_W];
    logic signed [15:0]     w_d [N_W];
    logic signed [15:0]     dw_eff;
    logic signed [23:0]     dw_ext;

    // Delta rounds toward -inf (arithmetic shift), result saturated to 16 bits.
    function automatic logic signed [15:0] apply_delta(input logic signed [15:0] w,
                                                       input logic signed [23:0] acc);
        logic signed [23:0] delta;
        logic signed [25:0] diff;
        delta = acc >>> Shift;
        diff  = 26'(w) - 26'(delta);
        if (diff > 26'sd32767) begin
            return 16'sh7fff;
        end else if (diff < -26'sd32768) begin
            return 16'sh8000;
        end
        return diff[15:0];
    endfunction

`ifdef WU_GRAD_CLIP_EN
    always_comb begin
        dw_eff = dw;
        if ($signed(dw) > GRAD_CLIP) begin
            dw_eff = GRAD_CLIP;
        end else if ($signed(dw) < -GRAD_CLIP) begin
            dw_eff = -GRAD_CLIP;
        end
    end
`else
    assign dw_eff = dw;
`endif

    assign dw_ext = {{8{dw_eff[15]}}, dw_eff};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        batch_d = batch_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        w_d     = w_q;
        unique case (state_q)
            StAccum: begin
                for (int i = 0; i < N_W; i++) begin
                    if (dw_valid && dw_idx == ADDR_W'(i)) begin
                        acc_d[i] = acc_q[i] + dw_ext;
                    end
                    if (w_load && w_load_idx == ADDR_W'(i)) begin
                        w_d[i] = w_load_data;
                    end
                end
                if (sample_done) begin
                    if (batch_q == {BATCH_LOG2{1'b1}}) begin
                        batch_d = '0;
                        k_d     = '0;
                        state_d = StApply;
                    end else begin
                        batch_d = batch_q + 1'b1;
                    end
                end
            end
            StApply: begin
                for (int i = 0; i < N_W; i++) begin
                    if (k_q == ADDR_W'(i)) begin
                        w_d[i]   = apply_delta(w_q[i], acc_q[i]);
                        acc_d[i] = '0;
                    end
                end
                if (k_q == ADDR_W'(N_W - 1)) begin
                    state_d = StAccum;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StAccum;
            k_q     <= '0;
            batch_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_W; i++) begin
                acc_q[i] <= '0;
                w_q[i]   <= W_INIT;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            batch_q <= batch_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        rd_w = '0;
        for (int i = 0; i < N_W; i++) begin
            if (rd_idx == ADDR_W'(i)) begin
                rd_w = w_q[i];
            end
        end
    end

    assign dw_ready  = (state_q == StAccum);
    assign upd_busy  = (state_q == StApply);
    assign upd_done  = done_q;
    assign batch_cnt = batch_q;

endmodule

// File: tb/tb_weight_update_module.sv
// Directed bench for weight_update_module: batch update, saturation, rounding,
// handshake during APPLY, reset mid-APPLY and optional gradient clipping.
module tb_weight_update_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        dw_valid;
    logic [2:0]  dw_idx;
    logic [15:0] dw;
    logic        dw_ready;
    logic        sample_done;
    logic        w_load;
    logic [2:0]  w_load_idx;
    logic [15:0] w_load_data;
    logic [2:0]  rd_idx;
    logic [15:0] rd_w;
    logic        upd_busy;
    logic        upd_done;
    logic [1:0]  batch_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_update_module dut (
        .clk         (clk),
        .rst         (rst),
        .dw_valid    (dw_valid),
        .dw_idx      (dw_idx),
        .dw          (dw),
        .dw_ready    (dw_ready),
        .sample_done (sample_done),
        .w_load      (w_load),
        .w_load_idx  (w_load_idx),
        .w_load_data (w_load_data),
        .rd_idx      (rd_idx),
        .rd_w        (rd_w),
        .upd_busy    (upd_busy),
        .upd_done    (upd_done),
        .batch_cnt   (batch_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input int idx, input logic [15:0] exp, input string tag);
        rd_idx = 3'(idx);
        #1;
        check(tag, rd_w, exp);
    endtask

    task automatic clear_inputs();
        dw_valid    = 1'b0;
        dw_idx      = '0;
        dw          = '0;
        sample_done = 1'b0;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_load_data = '0;
    endtask

    task automatic sample(input int idx, input logic [15:0] val, input bit combined);
        dw_valid = 1'b1;
        dw_idx   = 3'(idx);
        dw       = val;
        if (combined) begin
            sample_done = 1'b1;
            step();
        end else begin
            step();
            dw_valid    = 1'b0;
            sample_done = 1'b1;
            step();
        end
        clear_inputs();
    endtask

    task automatic batch(input int idx, input logic [15:0] val, input bit last_combined);
        for (int s = 0; s < 4; s++) begin
            sample(idx, val, last_combined && (s == 3));
        end
    endtask

    // Entered just after the edge that accepted the last sample_done.
    task automatic apply_wait();
        check("apply_busy", {15'd0, upd_busy}, 16'd1);
        check("apply_ready", {15'd0, dw_ready}, 16'd0);
        // Everything below must be ignored while applying.
        dw_valid    = 1'b1;
        dw_idx      = 3'd0;
        dw          = 16'h1000;
        sample_done = 1'b1;
        w_load      = 1'b1;
        w_load_idx  = 3'd0;
        w_load_data = 16'h1234;
        for (int i = 1; i < 8; i++) begin
            step();
        end
        check("apply_done_early", {15'd0, upd_done}, 16'd0);
        check("apply_busy_last", {15'd0, upd_busy}, 16'd1);
        clear_inputs();
        step();
        check("upd_done_pulse", {15'd0, upd_done}, 16'd1);
        check("post_busy", {15'd0, upd_busy}, 16'd0);
        check("post_ready", {15'd0, dw_ready}, 16'd1);
        check("post_batch_cnt", {14'd0, batch_cnt}, 16'd0);
        step();
        check("upd_done_single", {15'd0, upd_done}, 16'd0);
    endtask

    initial begin
        int pulses;
        clear_inputs();
        rd_idx = '0;
        rst    = 1'b0;
        step();
        step();
        rst = 1'b1;
        check("rst_ready", {15'd0, dw_ready}, 16'd1);
        check("rst_busy", {15'd0, upd_busy}, 16'd0);
        check("rst_done", {15'd0, upd_done}, 16'd0);
        check("rst_batch", {14'd0, batch_cnt}, 16'd0);
        chk_w(0, 16'h0000, "rst_w0");

        // Basic: 4 x 1024 -> acc 4096 -> delta 64.
        sample(0, 16'd1024, 1'b0);
        sample(0, 16'd1024, 1'b0);
        check("batch_cnt_2", {14'd0, batch_cnt}, 16'd2);
        sample(0, 16'd1024, 1'b0);
        check("batch_cnt_3", {14'd0, batch_cnt}, 16'd3);
        sample(0, 16'd1024, 1'b0);
        apply_wait();
        chk_w(0, 16'hffc0, "basic_w0");

        // Saturation, with last dw arriving together with the final sample_done.
        w_load      = 1'b1;
        w_load_idx  = 3'd1;
        w_load_data = 16'h7d00;
        step();
        clear_inputs();
        chk_w(1, 16'h7d00, "load_w1");
        batch(1, 16'h8000, 1'b1);
        apply_wait();
        chk_w(1, 16'h7fff, "sat_w1");
        chk_w(0, 16'hffc0, "apply_dw_ignored_w0");

        // Rounding toward -inf: acc -4 -> delta -1.
        batch(2, 16'hffff, 1'b0);
        apply_wait();
        chk_w(2, 16'h0001, "round_w2");
        chk_w(0, 16'hffc0, "keep_w0");
        chk_w(1, 16'h7fff, "keep_w1");
        chk_w(5, 16'h0000, "keep_w5");

        // Clip: 8192 clamps to 1024 when enabled.
        batch(3, 16'd8192, 1'b0);
        apply_wait();
`ifdef WU_GRAD_CLIP_EN
        chk_w(3, 16'hffc0, "clip_w3");
`else
        chk_w(3, 16'hfe00, "noclip_w3");
`endif

        // Reset in APPLY cycle 3.
        batch(4, 16'd1024, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_ready", {15'd0, dw_ready}, 16'd1);
        check("midrst_busy", {15'd0, upd_busy}, 16'd0);
        check("midrst_done", {15'd0, upd_done}, 16'd0);
        check("midrst_batch", {14'd0, batch_cnt}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk_w(i, 16'h0000, $sformatf("midrst_w%0d", i));
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (upd_done) pulses++;
        end
        check("midrst_no_pulse", 16'(pulses), 16'd0);
        // A zero batch leaves w4 at 0 only if acc[4] was cleared by reset.
        batch(4, 16'd0, 1'b0);
        apply_wait();
        chk_w(4, 16'h0000, "midrst_acc_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
